fetch_queue: RTL and testbench

Instruction prefetch queue for the SISC processor. It sits between the instruction memory and the instruction register. It generates the fetch address and buffers up to DEPTH fetched words, each tagged with its address. It presents them in order to the instruction register through a valid/ready handshake. A branch redirect flushes the queue, and fetch stops after a halt instruction is queued.

---
 rtl/sisc_defs.sv | 13 +
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetchq_fifo.sv | 50 +++++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sisc_defs.sv
// Shared SISC definitions: halt opcode, fetch FSM state encodings and default reset fetch address.
package sisc_defs;

  localparam logic [3:0]  HALT_OPCODE      = 4'hF;
  localparam logic [0:0]  RUN              = 1'b0;
  localparam logic [0:0]  HALTED           = 1'b1;
  localparam logic [15:0] RST_ADDR_DEFAULT = 16'h0000;

  function automatic logic is_halt(input logic [3:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bus of the prefetch queue: instruction memory port, IR handshake and branch redirect.
interface fetch_queue_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_valid;
  logic          out_ready;
  logic          redirect;
  logic [AW-1:0] redirect_addr;

  // master: the fetch queue; slave: instruction memory, IR and branch unit.
  modport master (
    output imem_addr, out_instr, out_pc, out_valid,
    input  imem_data, out_ready, redirect, redirect_addr
  );

  modport slave (
    input  imem_addr, out_instr, out_pc, out_valid,
    output imem_data, out_ready, redirect, redirect_addr
  );
endinterface

// File: rtl/fetchq_fifo.sv
// Entry storage for the fetch queue: power-of-two circular buffer with occupancy count and sync flush.
module fetchq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic                     clk,
  input  logic                     rst_f,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: the storage array is not reset; emptiness is tracked by count and rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// SISC instruction prefetch queue: fetch PC, RUN/HALTED FSM and in-order IR handshake.
// Optional perf counters (perf_fetched, perf_flushed) are built when FETCHQ_PERF_EN is defined.
module fetch_queue
  import sisc_defs::*;
#(
  parameter int            DEPTH    = 4,
  parameter int            AW       = 16,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RST_ADDR = RST_ADDR_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_f,
  input  logic         fetch_en,
  fetch_queue_if.master bus,
  output logic         halted
`ifdef FETCHQ_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_flushed
`endif
);

  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [AW-1:0]    fetch_pc;
  logic [0:0]       state;
  logic [CW-1:0]    count;
  logic [AW+DW-1:0] head;
  logic             out_valid;
  logic             push;
  logic             pop;

  // Valid is suppressed during a redirect so the IR never loads a wrong-path word.
  assign out_valid = (count != '0) && !bus.redirect;
  assign pop       = out_valid && bus.out_ready;
  assign push      = (state == RUN) && fetch_en && !bus.redirect && ((count < FULL) || pop);

  fetchq_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk   (clk),
    .rst_f (rst_f),
    .flush (bus.redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.imem_addr, bus.imem_data}),
    .rdata (head),
    .count (count)
  );

  assign bus.imem_addr              = fetch_pc;
  assign {bus.out_pc, bus.out_instr} = head;
  assign bus.out_valid              = out_valid;
  assign halted                     = (state == HALTED);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      fetch_pc <= RST_ADDR;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_addr;
    end else if (push) begin
      fetch_pc <= fetch_pc + 1'b1;
    end
  end

  // Only a pushed HLT word stops fetch; any redirect resumes it.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= RUN;
    end else if (bus.redirect) begin
      state <= RUN;
    end else if (push && is_halt(bus.imem_data[DW-1 -: 4])) begin
      state <= HALTED;
    end
  end

`ifdef FETCHQ_PERF_EN
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push)         perf_fetched <= perf_fetched + 32'd1;
      if (bus.redirect) perf_flushed <= perf_flushed + 32'(count);
    end
  end
`else
  // No counter state exists in this build.
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scoreboard bench for fetch_queue: expected IR loads are queued by the stimulus, checked by a monitor.
module tb_fetch_queue;

  localparam logic [15:0] HALT_AT = 16'h0043;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst_f;
  logic fetch_en;
  logic halted;
`ifdef FETCHQ_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int   errors;
  int   checks;
  exp_t exp_q[$];

  fetch_queue_if #(.AW(16), .DW(32)) bus ();

  fetch_queue #(
    .DEPTH    (4),
    .AW       (16),
    .DW       (32),
    .RST_ADDR (16'h0000)
  ) dut (
    .clk          (clk),
    .rst_f        (rst_f),
    .fetch_en     (fetch_en),
    .bus          (bus),
    .halted       (halted)
`ifdef FETCHQ_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word = 0x1000_0001 + addr, except one HLT word.
  always_comb begin
    bus.imem_data = 32'h1000_0001 + {16'h0000, bus.imem_addr};
    if (bus.imem_addr == HALT_AT) bus.imem_data = 32'hF000_0000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_load(input logic [15:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted IR load is compared against the next expected entry.
  always @(negedge clk) begin
    if (rst_f && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load_pc", 32'(bus.out_pc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("load_pc", 32'(bus.out_pc), 32'(e.pc));
        check("load_instr", bus.out_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    errors            = 0;
    checks            = 0;
    rst_f             = 1'b0;
    fetch_en          = 1'b0;
    bus.out_ready     = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 16'h0000;
    #2;
    check("rst_imem_addr", 32'(bus.imem_addr), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_pc", 32'(bus.out_pc), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
`ifdef FETCHQ_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_flushed", perf_flushed, 32'h0);
`endif

    // Streaming: addresses 0..4 loaded back to back, then 5 after the fill test.
    expect_load(16'h0000, 32'h1000_0001);
    expect_load(16'h0001, 32'h1000_0002);
    expect_load(16'h0002, 32'h1000_0003);
    expect_load(16'h0003, 32'h1000_0004);
    expect_load(16'h0004, 32'h1000_0005);
    expect_load(16'h0005, 32'h1000_0006);
    tick();
    rst_f         = 1'b1;
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    tick(); #2;
    check("first_push_addr", 32'(bus.imem_addr), 32'h1);
    check("first_valid", 32'(bus.out_valid), 32'h1);
    check("first_pc", 32'(bus.out_pc), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      check("stream_valid", 32'(bus.out_valid), 32'h1);
    end
    tick();
    bus.out_ready = 1'b0;
    #2;
    check("stream_end_addr", 32'(bus.imem_addr), 32'h6);
    check("stream_end_pc", 32'(bus.out_pc), 32'h5);

    // Fill with IR stalled: exactly three more pushes make four entries.
    repeat (4) tick();
    #2;
    check("full_hold_addr", 32'(bus.imem_addr), 32'h9);
    check("full_valid", 32'(bus.out_valid), 32'h1);
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #2;
    check("full_pop_push_addr", 32'(bus.imem_addr), 32'hA);
    check("full_pop_head", 32'(bus.out_pc), 32'h6);
    tick();
    check("full_count_kept", 32'(bus.imem_addr), 32'hA);

    // Redirect flushes four entries; valid is masked in the redirect cycle.
    bus.redirect      = 1'b1;
    bus.redirect_addr = 16'h0040;
    bus.out_ready     = 1'b1;
    #2;
    check("redirect_valid_low", 32'(bus.out_valid), 32'h0);
    expect_load(16'h0040, 32'h1000_0041);
    expect_load(16'h0041, 32'h1000_0042);
    expect_load(16'h0042, 32'h1000_0043);
    expect_load(16'h0043, 32'hF000_0000);
    tick();
    bus.redirect = 1'b0;
    #2;
    check("redirect_addr", 32'(bus.imem_addr), 32'h40);
    check("redirect_empty", 32'(bus.out_valid), 32'h0);
`ifdef FETCHQ_PERF_EN
    check("perf_flushed_4", perf_flushed, 32'd4);
`endif
    tick(); #2;
    check("redirect_valid", 32'(bus.out_valid), 32'h1);
    check("redirect_pc", 32'(bus.out_pc), 32'h40);

    // HLT at 0x43 stops fetch; the queue drains.
    tick(); tick(); #2;
    check("pre_halt", 32'(halted), 32'h0);
    tick(); #2;
    check("halted", 32'(halted), 32'h1);
    tick(); #2;
    check("halt_drained", 32'(bus.out_valid), 32'h0);
    check("halt_addr_hold", 32'(bus.imem_addr), 32'h44);
    tick(); tick();
    bus.redirect      = 1'b1;
    bus.redirect_addr = 16'h0010;
    #2;
    check("halted_until_redirect", 32'(halted), 32'h1);
    expect_load(16'h0010, 32'h1000_0011);
    expect_load(16'h0011, 32'h1000_0012);
    tick();
    bus.redirect = 1'b0;
    #2;
    check("resume_run", 32'(halted), 32'h0);
    check("resume_addr", 32'(bus.imem_addr), 32'h10);
    tick(); tick();
    fetch_en = 1'b0;
    tick(); tick();

    // fetch_pc wrap 0xFFFF -> 0x0000.
    bus.redirect      = 1'b1;
    bus.redirect_addr = 16'hFFFE;
    fetch_en          = 1'b1;
    expect_load(16'hFFFE, 32'h1000_FFFF);
    expect_load(16'hFFFF, 32'h1001_0000);
    expect_load(16'h0000, 32'h1000_0001);
    tick();
    bus.redirect = 1'b0;
    tick(); #2;
    check("wrap_ffff", 32'(bus.imem_addr), 32'hFFFF);
    tick(); #2;
    check("wrap_0000", 32'(bus.imem_addr), 32'h0000);
    tick(); #2;
    check("wrap_0001", 32'(bus.imem_addr), 32'h0001);
    tick();
    bus.out_ready = 1'b0;
    tick(); tick();
    check("prefill_valid", 32'(bus.out_valid), 32'h1);
    check("prefill_pc", 32'(bus.out_pc), 32'h1);
`ifdef FETCHQ_PERF_EN
    check("perf_fetched_22", perf_fetched, 32'd22);
    check("perf_flushed_total", perf_flushed, 32'd4);
`endif

    // Asynchronous reset mid-fill.
    #1;
    rst_f    = 1'b0;
    fetch_en = 1'b0;
    #1;
    check("arst_imem_addr", 32'(bus.imem_addr), 32'h0);
    check("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check("arst_out_instr", bus.out_instr, 32'h0);
    check("arst_out_pc", 32'(bus.out_pc), 32'h0);
    check("arst_halted", 32'(halted), 32'h0);
`ifdef FETCHQ_PERF_EN
    check("arst_perf_fetched", perf_fetched, 32'h0);
    check("arst_perf_flushed", perf_flushed, 32'h0);
`endif
    tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
